// File: rtl/mem_nr1w_init.sv
// NUM_READ-port / single-write-port synchronous memory that zeroes itself after every reset.
// Define MEM_BYPASS_EN for write-first collisions; otherwise collisions are read-first.
module mem_nr1w_init #(
  parameter int DEPTH_LOG2 = 4,
  parameter int WIDTH      = 32,
  parameter int NUM_READ   = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_READ*DEPTH_LOG2-1:0] read_addr,
  input  logic [NUM_READ-1:0]            read,
  output logic [NUM_READ*WIDTH-1:0]      read_data,
  input  logic [DEPTH_LOG2-1:0]          write_addr,
  input  logic                           write,
  input  logic [WIDTH-1:0]               write_data,
  output logic                           ready
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                r_state;
  logic [DEPTH_LOG2-1:0] r_init_cnt;
  logic                  r_ready;
  logic [WIDTH-1:0]      r_mem [DEPTH];

  logic                  w_mem_we;
  logic [DEPTH_LOG2-1:0] w_mem_addr;
  logic [WIDTH-1:0]      w_mem_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
      r_ready    <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_init_cnt <= r_init_cnt + 1'b1;
          // Leave on the last entry so the counter never wraps onto entry 0 again.
          if (r_init_cnt == {DEPTH_LOG2{1'b1}}) begin
            r_state <= ST_RUN;
            r_ready <= 1'b1;
          end
        end
        ST_RUN:  r_state <= ST_RUN;
        default: r_state <= ST_INIT;
      endcase
    end
  end

  // One physical write port shared between the zero sweep and external writes.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_addr  = write_addr;
    w_mem_wdata = write_data;
    if (!rst) begin
      if (r_state == ST_INIT) begin
        w_mem_we    = 1'b1;
        w_mem_addr  = r_init_cnt;
        w_mem_wdata = '0;
      end else if (write) begin
        w_mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_READ; gi++) begin : g_rd
      logic [DEPTH_LOG2-1:0] w_raddr;
      logic [WIDTH-1:0]      w_rdata;
      logic [WIDTH-1:0]      r_rdata;

      assign w_raddr = read_addr[gi*DEPTH_LOG2 +: DEPTH_LOG2];
`ifdef MEM_BYPASS_EN
      assign w_rdata = (write && (write_addr == w_raddr)) ? write_data : r_mem[w_raddr];
`else
      assign w_rdata = r_mem[w_raddr];
`endif

      // Reads are only honoured in RUN, so the array is never read before the sweep.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_rdata <= '0;
        end else if ((r_state == ST_RUN) && read[gi]) begin
          r_rdata <= w_rdata;
        end
      end

      assign read_data[gi*WIDTH +: WIDTH] = r_rdata;
    end
  endgenerate

  assign ready = r_ready;

endmodule

// File: tb/tb_mem_nr1w_init.sv
// Scoreboard bench for mem_nr1w_init (DEPTH_LOG2=4, WIDTH=32, NUM_READ=2).
// Honours MEM_BYPASS_EN to pick the expected collision behaviour.
module tb_mem_nr1w_init;
  localparam int DL = 4;
  localparam int W  = 32;
  localparam int NR = 2;
  localparam int DEPTH = 16;
`ifdef MEM_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [NR*DL-1:0] read_addr = '0;
  logic [NR-1:0]  read = '0;
  logic [NR*W-1:0] read_data;
  logic [DL-1:0]  write_addr = '0;
  logic           write = 1'b0;
  logic [W-1:0]   write_data = '0;
  logic           ready;

  always #5 clk = ~clk;

  mem_nr1w_init #(.DEPTH_LOG2(DL), .WIDTH(W), .NUM_READ(NR)) dut (
    .clk        (clk),
    .rst        (rst),
    .read_addr  (read_addr),
    .read       (read),
    .read_data  (read_data),
    .write_addr (write_addr),
    .write      (write),
    .write_data (write_data),
    .ready      (ready)
  );

  // kind 0: read_data[port], kind 1: ready
  typedef struct {
    int          due;
    int          kind;
    int          port;
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  logic [31:0] mdl [DEPTH];
  logic [31:0] exp_rd [NR];
  bit          m_ready = 1'b0;
  int          init_left = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every expectation that falls due after this edge.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      if (e.kind == 1) act = {31'b0, ready};
      else             act = read_data[e.port*W +: W];
      n_vec++;
      if (e.due != cyc || act !== e.val) begin
        n_err++;
        $display("FAIL %s kind=%0d port=%0d cyc=%0d got=%h want=%h", e.tag, e.kind, e.port, cyc, act, e.val);
      end else if (e.tag != "rand") begin
        $display("ok   %s kind=%0d port=%0d cyc=%0d data=%h", e.tag, e.kind, e.port, cyc, act);
      end
    end
  end

  function automatic void push(input int kind, input int port, input logic [31:0] val, input string tag);
    exp_t e;
    e.due = cyc + 1; e.kind = kind; e.port = port; e.val = val; e.tag = tag;
    q.push_back(e);
  endfunction

  // Hand-computed expectations for the edge produced by the next drive() call.
  function automatic void expect_rd(input int port, input logic [31:0] val, input string tag);
    push(0, port, val, tag);
  endfunction

  function automatic void expect_ready(input bit val, input string tag);
    push(1, 0, {31'b0, val}, tag);
  endfunction

  task automatic drive(input bit r, input logic [1:0] rd, input int a0, input int a1,
                       input bit wr, input int wa, input logic [31:0] wd, input string tag);
    int a;
    rst = r; read = rd; read_addr = {4'(a1), 4'(a0)};
    write = wr; write_addr = 4'(wa); write_data = wd;
    if (r) begin
      m_ready = 1'b0; init_left = DEPTH;
      exp_rd[0] = '0; exp_rd[1] = '0;
    end else if (!m_ready) begin
      init_left--;
      if (init_left == 0) begin
        m_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
      end
    end else begin
      for (int p = 0; p < NR; p++) begin
        if (rd[p]) begin
          a = (p == 0) ? a0 : a1;
          if (BYP && wr && wa == a) exp_rd[p] = wd;
          else                      exp_rd[p] = mdl[a];
        end
      end
      if (wr) mdl[wa] = wd;
    end
    push(1, 0, {31'b0, m_ready}, tag);
    push(0, 0, exp_rd[0], tag);
    push(0, 1, exp_rd[1], tag);
    @(posedge clk); #1;
  endtask

  initial begin
    // T1: two reset cycles, then the sweep; reads and writes during INIT are ignored.
    expect_ready(1'b0, "t1_rst");
    drive(1, 2'b00, 0, 0, 0, 0, 0, "t1_rst");
    drive(1, 2'b00, 0, 0, 0, 0, 0, "t1_rst");
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 14) expect_ready(1'b0, "t1_ready_lo");
      if (i == 15) expect_ready(1'b1, "t1_ready_hi");
      expect_rd(0, 32'h0, "t1_init_rd0");
      expect_rd(1, 32'h0, "t1_init_rd1");
      drive(0, 2'b11, i, 15 - i, (i == 3 || i == 15), 7, 32'h55, "t5_init_wr");
    end
    for (int i = 0; i < DEPTH; i++) begin
      expect_rd(0, 32'h0, "t1_zero_p0");
      expect_rd(1, 32'h0, "t1_zero_p1");
      drive(0, 2'b11, i, i, 0, 0, 0, "t1_zero");
    end

    // T2: basic write then dual read.
    drive(0, 2'b00, 0, 0, 1, 5, 32'hDEADBEEF, "t2_wr");
    expect_rd(0, 32'hDEADBEEF, "t2_p0");
    expect_rd(1, 32'hDEADBEEF, "t2_p1");
    drive(0, 2'b11, 5, 5, 0, 0, 0, "t2_rd");

    // T3: hold while read disabled and address overwritten.
    expect_rd(0, 32'hDEADBEEF, "t3_rd");
    drive(0, 2'b01, 5, 0, 0, 0, 0, "t3_rd");
    for (int i = 0; i < 3; i++) begin
      expect_rd(0, 32'hDEADBEEF, "t3_hold");
      drive(0, 2'b00, 0, 0, 1, 5, 32'h1, "t3_hold");
    end
    expect_rd(1, 32'h1, "t3_new");
    drive(0, 2'b10, 0, 5, 0, 0, 0, "t3_new");

    // T4: same-cycle read/write collision on port 1.
    drive(0, 2'b00, 0, 0, 1, 3, 32'hA, "t4_wr");
    expect_rd(1, BYP ? 32'hB : 32'hA, "t4_collide");
    drive(0, 2'b10, 0, 3, 1, 3, 32'hB, "t4_collide");
    expect_rd(1, 32'hB, "t4_after");
    drive(0, 2'b10, 0, 3, 0, 0, 0, "t4_after");

    // T6: fill with index, reset mid-run, everything reads back zero.
    for (int i = 0; i < DEPTH; i++) drive(0, 2'b00, 0, 0, 1, i, 32'(i), "t6_fill");
    expect_rd(0, 32'h9, "t6_pre");
    drive(0, 2'b01, 9, 0, 0, 0, 0, "t6_pre");
    expect_ready(1'b0, "t6_ready_drop");
    expect_rd(0, 32'h0, "t6_flush");
    drive(1, 2'b11, 9, 9, 1, 9, 32'hFFFF, "t6_rst");
    for (int i = 0; i < DEPTH; i++) drive(0, 2'b11, i, i, 0, 0, 0, "t6_init");
    for (int i = 0; i < DEPTH; i++) begin
      expect_rd(0, 32'h0, "t6_zero_p0");
      expect_rd(1, 32'h0, "t6_zero_p1");
      drive(0, 2'b11, i, 15 - i, 0, 0, 0, "t6_zero");
    end

    // Random traffic against the model, with rare resets.
    for (int i = 0; i < 10000; i++) begin
      drive(($urandom_range(0, 499) == 0), 2'($urandom), $urandom_range(0, 15), $urandom_range(0, 15),
            1'($urandom), $urandom_range(0, 15), $urandom, "rand");
    end

    drive(0, 2'b00, 0, 0, 0, 0, 0, "tail");
    @(posedge clk); #1;
    @(negedge clk); #1;
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain got=%0d pending want=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
